// File: rtl/down_timer_pkg.sv
// Shared constants for the programmable down-counting timer.
package down_timer_pkg;

    localparam int unsigned DEFAULT_WIDTH = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/down_timer.sv
// Programmable down timer: load, count to zero, one-cycle terminal-count
// pulse, one-shot or auto-reload, with hold and abort.
module down_timer
    import down_timer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             cl,
    input  logic             r,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             start,
    input  logic             hold,
    input  logic             auto,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             cnt_zero;
    logic             cnt_one;
    logic             reload_zero;

    assign cnt_zero    = (cnt_q == WIDTH'(0));
    assign cnt_one     = (cnt_q == WIDTH'(1));
    assign reload_zero = (reload_q == WIDTH'(0));

    // Next-state logic; priority is clr > ld > start > hold > count.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        busy_d   = busy_q;
        done_d   = done_q;

        if (clr) begin
            state_d = ST_IDLE;
            cnt_d   = reload_q;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else if (ld) begin
            reload_d = ld_val;
            // While counting, the new value only lands at the next reload.
            if ((state_q == ST_IDLE) || (state_q == ST_DONE)) begin
                state_d = ST_IDLE;
                cnt_d   = ld_val;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start && !cnt_zero) begin
                        state_d = ST_RUN;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (hold) begin
                        state_d = ST_HOLD;
                    end else if (cnt_one) begin
                        cnt_d = WIDTH'(0);
                        tc_d  = 1'b1;
                        if (!auto) begin
                            state_d = ST_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else if (cnt_zero) begin
                        // Zero reached in auto mode: reload, or finish if nothing to reload.
                        if (!reload_zero) begin
                            cnt_d = reload_q;
                        end else begin
                            state_d = ST_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - WIDTH'(1);
                    end
                end
                ST_HOLD: begin
                    if (!hold) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge cl) begin
        if (!r) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign cnt  = cnt_q;
    assign tc   = tc_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_down_timer.sv
// Directed self-checking bench for down_timer with hand-computed expectations.
module tb_down_timer;

    localparam int unsigned W = 3;

    logic         cl;
    logic         r;
    logic         clr;
    logic         ld;
    logic [W-1:0] ld_val;
    logic         start;
    logic         hold;
    logic         auto;
    logic [W-1:0] cnt;
    logic         tc;
    logic         busy;
    logic         done;

    int vectors;
    int miscompares;

    down_timer #(.WIDTH(W)) dut (
        .cl     (cl),
        .r      (r),
        .clr    (clr),
        .ld     (ld),
        .ld_val (ld_val),
        .start  (start),
        .hold   (hold),
        .auto   (auto),
        .cnt    (cnt),
        .tc     (tc),
        .busy   (busy),
        .done   (done)
    );

    initial cl = 1'b0;
    always #5 cl = ~cl;

    // Advance one edge, then compare outputs 1ns later.
    task automatic step(input string tag, input logic [W-1:0] ec,
                        input logic et, input logic eb, input logic ed);
        @(posedge cl);
        #1;
        vectors++;
        assert ({cnt, tc, busy, done} === {ec, et, eb, ed})
        else begin
            miscompares++;
            $error("FAIL %s: observed cnt=%0d tc=%b busy=%b done=%b, expected cnt=%0d tc=%b busy=%b done=%b",
                   tag, cnt, tc, busy, done, ec, et, eb, ed);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        r      = 1'b0;
        clr    = 1'b0;
        ld     = 1'b1;
        ld_val = 3'd5;
        start  = 1'b1;
        hold   = 1'b0;
        auto   = 1'b0;

        // 1: reset overrides ld/start
        step("rst0", 3'd0, 1'b0, 1'b0, 1'b0);
        step("rst1", 3'd0, 1'b0, 1'b0, 1'b0);
        r = 1'b1; ld = 1'b0; start = 1'b0;

        // 2: one-shot from 5
        ld = 1'b1; ld_val = 3'd5;
        step("os_ld", 3'd5, 1'b0, 1'b0, 1'b0);
        ld = 1'b0; start = 1'b1;
        step("os_start", 3'd5, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        for (int k = 4; k >= 1; k--) step("os_cnt", W'(k), 1'b0, 1'b1, 1'b0);
        step("os_tc", 3'd0, 1'b1, 1'b0, 1'b1);
        step("os_after", 3'd0, 1'b0, 1'b0, 1'b1);
        start = 1'b1;
        step("os_restart0", 3'd0, 1'b0, 1'b0, 1'b1);
        start = 1'b0;

        // 3: auto-reload from 2, reload changed mid-run
        auto = 1'b1; ld = 1'b1; ld_val = 3'd2;
        step("ar_ld", 3'd2, 1'b0, 1'b0, 1'b0);
        ld = 1'b0; start = 1'b1;
        step("ar_start", 3'd2, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        step("ar_1", 3'd1, 1'b0, 1'b1, 1'b0);
        step("ar_tc1", 3'd0, 1'b1, 1'b1, 1'b0);
        step("ar_rl", 3'd2, 1'b0, 1'b1, 1'b0);
        ld = 1'b1; ld_val = 3'd4;
        step("ar_ldrun", 3'd2, 1'b0, 1'b1, 1'b0);
        ld = 1'b0;
        step("ar_1b", 3'd1, 1'b0, 1'b1, 1'b0);
        step("ar_tc2", 3'd0, 1'b1, 1'b1, 1'b0);
        step("ar_newrl", 3'd4, 1'b0, 1'b1, 1'b0);
        step("ar_3", 3'd3, 1'b0, 1'b1, 1'b0);
        clr = 1'b1;
        step("ar_clr", 3'd4, 1'b0, 1'b0, 1'b0);
        clr = 1'b0; auto = 1'b0;

        // 4: hold at 3 for three cycles
        ld = 1'b1; ld_val = 3'd6;
        step("h_ld", 3'd6, 1'b0, 1'b0, 1'b0);
        ld = 1'b0; start = 1'b1;
        step("h_start", 3'd6, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        for (int k = 5; k >= 3; k--) step("h_cnt", W'(k), 1'b0, 1'b1, 1'b0);
        hold = 1'b1;
        for (int k = 0; k < 3; k++) step("h_frozen", 3'd3, 1'b0, 1'b1, 1'b0);
        hold = 1'b0;
        step("h_resume", 3'd3, 1'b0, 1'b1, 1'b0);
        step("h_dec", 3'd2, 1'b0, 1'b1, 1'b0);
        clr = 1'b1;
        step("h_clr", 3'd6, 1'b0, 1'b0, 1'b0);
        clr = 1'b0;

        // 5: zero load ignored, full-scale one-shot
        ld = 1'b1; ld_val = 3'd0;
        step("z_ld", 3'd0, 1'b0, 1'b0, 1'b0);
        ld = 1'b0; start = 1'b1;
        step("z_start", 3'd0, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        step("z_idle", 3'd0, 1'b0, 1'b0, 1'b0);
        ld = 1'b1; ld_val = 3'd7;
        step("m_ld", 3'd7, 1'b0, 1'b0, 1'b0);
        ld = 1'b0; start = 1'b1;
        step("m_start", 3'd7, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        for (int k = 6; k >= 1; k--) step("m_cnt", W'(k), 1'b0, 1'b1, 1'b0);
        step("m_tc", 3'd0, 1'b1, 1'b0, 1'b1);

        // 6: clr mid-run, then reset mid-run drops the reload value
        ld = 1'b1; ld_val = 3'd6;
        step("c_ld", 3'd6, 1'b0, 1'b0, 1'b0);
        ld = 1'b0; start = 1'b1;
        step("c_start", 3'd6, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        step("c_5", 3'd5, 1'b0, 1'b1, 1'b0);
        step("c_4", 3'd4, 1'b0, 1'b1, 1'b0);
        clr = 1'b1;
        step("c_clr", 3'd6, 1'b0, 1'b0, 1'b0);
        clr = 1'b0; start = 1'b1;
        step("c_restart", 3'd6, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        for (int k = 5; k >= 2; k--) step("c_cnt", W'(k), 1'b0, 1'b1, 1'b0);
        r = 1'b0;
        step("c_rst", 3'd0, 1'b0, 1'b0, 1'b0);
        r = 1'b1; clr = 1'b1;
        step("c_reload_lost", 3'd0, 1'b0, 1'b0, 1'b0);
        clr = 1'b0; start = 1'b1;
        step("c_start0", 3'd0, 1'b0, 1'b0, 1'b0);
        start = 1'b0;

        // ld+start together in IDLE: ld wins
        ld = 1'b1; start = 1'b1; ld_val = 3'd2;
        step("ls_ld", 3'd2, 1'b0, 1'b0, 1'b0);
        ld = 1'b0;
        step("ls_start", 3'd2, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        step("ls_1", 3'd1, 1'b0, 1'b1, 1'b0);
        // hold on the cnt==1 edge suppresses tc until resume
        hold = 1'b1;
        step("ls_hold", 3'd1, 1'b0, 1'b1, 1'b0);
        hold = 1'b0;
        step("ls_resume", 3'd1, 1'b0, 1'b1, 1'b0);
        step("ls_tc", 3'd0, 1'b1, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
